// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: standard video mode timings and the axis-total helper
package vga_timing_pkg;

    typedef struct packed {
        int   h_active;
        int   h_fp;
        int   h_sync;
        int   h_bp;
        int   v_active;
        int   v_fp;
        int   v_sync;
        int   v_bp;
        logic hs_pol;
        logic vs_pol;
    } vga_mode_t;

    localparam vga_mode_t MODE_640X480_60 = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    localparam vga_mode_t MODE_800X600_72 = '{800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1};

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis (pixels of a line or lines of a frame).
// in_active/sync are decoded from the next count so the parent can register them in step with count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0,
    parameter int W      = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         in_active,
    output logic         sync
);
    localparam int         TOTAL  = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [W:0] LAST   = (W+1)'(TOTAL - 1);
    localparam logic [W:0] A_END  = (W+1)'(ACTIVE);
    localparam logic [W:0] S_BEG  = (W+1)'(ACTIVE + FP);
    localparam logic [W:0] S_END  = (W+1)'(ACTIVE + FP + SYNC);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        wrap      = step && ({1'b0, count_q} == LAST);
        count_d   = wrap ? '0 : count_q + W'(step);
        in_active = {1'b0, count_d} < A_END;
        sync      = ({1'b0, count_d} >= S_BEG && {1'b0, count_d} < S_END) ? POL : ~POL;
    end

    // Park on the last back-porch position so the first step wraps to 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count_q <= W'(TOTAL - 1);
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing with pixel prescaler, line/frame strobes and frame counter
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = MODE_640X480_60.h_active,
    parameter int H_FP     = MODE_640X480_60.h_fp,
    parameter int H_SYNC   = MODE_640X480_60.h_sync,
    parameter int H_BP     = MODE_640X480_60.h_bp,
    parameter int V_ACTIVE = MODE_640X480_60.v_active,
    parameter int V_FP     = MODE_640X480_60.v_fp,
    parameter int V_SYNC   = MODE_640X480_60.v_sync,
    parameter int V_BP     = MODE_640X480_60.v_bp,
    parameter bit HS_POL   = MODE_640X480_60.hs_pol,
    parameter bit VS_POL   = MODE_640X480_60.vs_pol,
    parameter int CLK_DIV  = 2,
    parameter int CNT_W    = 10,
    parameter int FRAME_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic [CNT_W-1:0]   hcount,
    output logic [CNT_W-1:0]   vcount,
    output logic               vid,
    output logic               hs,
    output logic               vs,
    output logic               pix_ce,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);
    localparam int H_TOTAL   = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL   = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int MAX_TOTAL = H_TOTAL > V_TOTAL ? H_TOTAL : V_TOTAL;
    localparam int PW        = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    if (CLK_DIV < 1 || CNT_W < 1 || FRAME_W < 1 || H_SYNC < 1 || V_SYNC < 1 ||
        (CNT_W < 31 && (1 << CNT_W) < MAX_TOTAL)) begin : g_param_check
        $fatal(1, "vga_timing_gen: illegal parameter set");
    end

    logic [PW-1:0]      pre_q, pre_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               vid_q, vid_d, hs_q, vs_q;
    logic               pix_ce_q, line_start_q, frame_start_q;
    logic               tick, h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .W(CNT_W)
    ) u_h (
        .clk(clk), .reset(reset), .step(tick),
        .count(hcount), .wrap(h_wrap), .in_active(h_act), .sync(h_sync)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .W(CNT_W)
    ) u_v (
        .clk(clk), .reset(reset), .step(h_wrap),
        .count(vcount), .wrap(v_wrap), .in_active(v_act), .sync(v_sync)
    );

    // A vertical wrap only happens on a horizontal wrap, so it marks the new (0,0).
    always_comb begin
        tick        = enable && (pre_q == PW'(CLK_DIV - 1));
        pre_d       = !enable ? pre_q : tick ? '0 : pre_q + PW'(1);
        frame_cnt_d = frame_cnt_q + FRAME_W'(v_wrap);
        vid_d       = h_act && v_act;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q         <= '0;
            frame_cnt_q   <= '0;
            vid_q         <= 1'b0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            pix_ce_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pre_q         <= pre_d;
            frame_cnt_q   <= frame_cnt_d;
            vid_q         <= vid_d;
            hs_q          <= h_sync;
            vs_q          <= v_sync;
            pix_ce_q      <= tick;
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
        end
    end

    assign vid         = vid_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign pix_ce      = pix_ce_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three instances (default 640x480 /2, small /3, small /1 with positive hs)
// checked every cycle against a tick-count position model plus directed literal checks.
module tb_vga_timing_gen;

    typedef struct {
        int ha, hf, hsw, hb, va, vf, vsw, vb, div;
        bit hp, vp;
    } geo_t;

    typedef struct {
        longint h, v, fc;
        bit vid, hsy, vsy, pce, ls, fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst0 = 1'b0, rst1 = 1'b0, rst2 = 1'b0;
    logic en0 = 1'b1, en1 = 1'b1, en2 = 1'b1;
    logic [9:0]  hc [3];
    logic [9:0]  vc [3];
    logic [15:0] fc [3];
    logic vid [3], hs [3], vs [3], pce [3], ls [3], fs [3];

    int total = 0;
    int bad = 0;
    longint me [3];
    bit mlt [3];

    always #5 clk = ~clk;

    vga_timing_gen dut0 (
        .clk(clk), .reset(rst0), .enable(en0), .hcount(hc[0]), .vcount(vc[0]), .vid(vid[0]),
        .hs(hs[0]), .vs(vs[0]), .pix_ce(pce[0]), .line_start(ls[0]), .frame_start(fs[0]),
        .frame_cnt(fc[0])
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(3), .CNT_W(10), .FRAME_W(16)
    ) dut1 (
        .clk(clk), .reset(rst1), .enable(en1), .hcount(hc[1]), .vcount(vc[1]), .vid(vid[1]),
        .hs(hs[1]), .vs(vs[1]), .pix_ce(pce[1]), .line_start(ls[1]), .frame_start(fs[1]),
        .frame_cnt(fc[1])
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(1), .CNT_W(10), .FRAME_W(16)
    ) dut2 (
        .clk(clk), .reset(rst2), .enable(en2), .hcount(hc[2]), .vcount(vc[2]), .vid(vid[2]),
        .hs(hs[2]), .vs(vs[2]), .pix_ce(pce[2]), .line_start(ls[2]), .frame_start(fs[2]),
        .frame_cnt(fc[2])
    );

    function automatic geo_t geo(input int i);
        geo_t g;
        if (i == 0)
            g = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, 1'b0};
        else
            g = '{8, 2, 3, 2, 6, 1, 2, 2, (i == 1) ? 3 : 1, (i == 2), 1'b0};
        return g;
    endfunction

    // Position after e enabled clocks: n = e/div ticks; tick k (k>=1) shows raster index k-1.
    function automatic exp_t model(input geo_t g, input longint e, input bit lt);
        exp_t x;
        longint ht, vt, n, fr, idx;
        ht = g.ha + g.hf + g.hsw + g.hb;
        vt = g.va + g.vf + g.vsw + g.vb;
        fr = ht * vt;
        n  = e / g.div;
        if (n == 0) begin
            x.h = ht - 1;
            x.v = vt - 1;
            x.fc = 0;
        end else begin
            idx = (n - 1) % fr;
            x.h = idx % ht;
            x.v = idx / ht;
            x.fc = ((n - 1) / fr + 1) % 65536;
        end
        x.vid = (x.h < g.ha) && (x.v < g.va);
        x.hsy = (x.h >= g.ha + g.hf && x.h < g.ha + g.hf + g.hsw) ? g.hp : !g.hp;
        x.vsy = (x.v >= g.va + g.vf && x.v < g.va + g.vf + g.vsw) ? g.vp : !g.vp;
        x.pce = lt;
        x.ls  = lt && (x.h == 0);
        x.fs  = lt && (x.h == 0) && (x.v == 0);
        return x;
    endfunction

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t x;
        logic r, en;
        for (int i = 0; i < 3; i++) begin
            r  = (i == 0) ? rst0 : (i == 1) ? rst1 : rst2;
            en = (i == 0) ? en0 : (i == 1) ? en1 : en2;
            if (!r) begin
                me[i] = 0;
                mlt[i] = 1'b0;
            end else if (en) begin
                me[i] = me[i] + 1;
                mlt[i] = (me[i] % geo(i).div) == 0;
            end else begin
                mlt[i] = 1'b0;
            end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            x = model(geo(i), me[i], mlt[i]);
            chk($sformatf("d%0d.hcount", i), hc[i], x.h);
            chk($sformatf("d%0d.vcount", i), vc[i], x.v);
            chk($sformatf("d%0d.vid", i), vid[i], x.vid);
            chk($sformatf("d%0d.hs", i), hs[i], x.hsy);
            chk($sformatf("d%0d.vs", i), vs[i], x.vsy);
            chk($sformatf("d%0d.pix_ce", i), pce[i], x.pce);
            chk($sformatf("d%0d.line_start", i), ls[i], x.ls);
            chk($sformatf("d%0d.frame_start", i), fs[i], x.fs);
            chk($sformatf("d%0d.frame_cnt", i), fc[i], x.fc);
        end
    end

    initial begin
        fork
            begin : b0
                int k, nlow, nvid, hmin, hmax;
                repeat (5) @(negedge clk);
                chk("rst_hcount", hc[0], 799);
                chk("rst_vcount", vc[0], 524);
                chk("rst_vid", vid[0], 0);
                chk("rst_hs", hs[0], 1);
                chk("rst_vs", vs[0], 1);
                chk("rst_frame_cnt", fc[0], 0);
                chk("rst_strobes", {pce[0], ls[0], fs[0]}, 0);
                rst0 = 1'b1;
                @(posedge clk); #1;
                chk("edge1_hcount", hc[0], 799);
                @(posedge clk); #1;
                chk("edge2_hcount", hc[0], 0);
                chk("edge2_vcount", vc[0], 0);
                chk("edge2_vid", vid[0], 1);
                chk("edge2_strobes", {pce[0], ls[0], fs[0]}, 3'b111);
                chk("edge2_frame_cnt", fc[0], 1);
                k = 0; nlow = 0; nvid = 0; hmin = 9999; hmax = 0;
                do begin
                    if (!hs[0]) begin
                        nlow++;
                        if (hc[0] < hmin) hmin = hc[0];
                        if (hc[0] > hmax) hmax = hc[0];
                    end
                    if (vid[0]) nvid++;
                    @(posedge clk); #1;
                    k++;
                    if (k == 1) chk("pix_ce_one_clk", pce[0], 0);
                end while (!ls[0] && k < 4000);
                chk("line_period_clks", k, 1600);
                chk("hs_low_clks", nlow, 192);
                chk("hs_first_h", hmin, 656);
                chk("hs_last_h", hmax, 751);
                chk("vid_clks", nvid, 1280);
                k = 0;
                while (!(hc[0] == 100 && pce[0]) && k < 4000) begin
                    @(posedge clk); #1;
                    k++;
                end
                chk("reach_h100", hc[0], 100);
                en0 = 1'b0;
                repeat (37) begin
                    @(posedge clk); #1;
                    chk("freeze_hcount", hc[0], 100);
                    chk("freeze_pix_ce", pce[0], 0);
                    chk("freeze_vid", vid[0], 1);
                end
                en0 = 1'b1;
                k = 0;
                do begin
                    @(posedge clk); #1;
                    k++;
                end while (hc[0] != 101 && k < 10);
                chk("resume_clks", k, 2);
                repeat (2500) @(negedge clk) begin
                    en0  = ($urandom_range(0, 3) != 0);
                    rst0 = ($urandom_range(0, 499) != 0);
                end
                @(negedge clk) rst0 = 1'b1;
            end
            begin : b1
                int k, nvs, vmin, vmax;
                repeat (3) @(negedge clk);
                rst1 = 1'b1;
                k = 0;
                do begin
                    @(posedge clk); #1;
                    k++;
                end while (!fs[1] && k < 20);
                chk("d1_first_fs_clks", k, 3);
                chk("d1_first_frame_cnt", fc[1], 1);
                k = 0; nvs = 0; vmin = 9999; vmax = 0;
                do begin
                    if (!vs[1]) begin
                        nvs++;
                        if (vc[1] < vmin) vmin = vc[1];
                        if (vc[1] > vmax) vmax = vc[1];
                    end
                    @(posedge clk); #1;
                    k++;
                end while (!fs[1] && k < 2000);
                chk("d1_frame_period_clks", k, 495);
                chk("d1_vs_low_clks", nvs, 90);
                chk("d1_vs_first_v", vmin, 7);
                chk("d1_vs_last_v", vmax, 8);
                chk("d1_second_frame_cnt", fc[1], 2);
                repeat (3500) @(negedge clk) begin
                    en1  = ($urandom_range(0, 3) != 0);
                    rst1 = ($urandom_range(0, 299) != 0);
                end
                @(negedge clk) rst1 = 1'b1;
            end
            begin : b2
                int k, nhs, hmin, hmax;
                repeat (3) @(negedge clk);
                rst2 = 1'b1;
                k = 0;
                do begin
                    @(posedge clk); #1;
                    k++;
                end while (!(ls[2] && vc[2] == 5) && k < 400);
                chk("d2_reach_v5", vc[2], 5);
                k = 0; nhs = 0; hmin = 9999; hmax = 0;
                do begin
                    if (hs[2]) begin
                        nhs++;
                        if (hc[2] < hmin) hmin = hc[2];
                        if (hc[2] > hmax) hmax = hc[2];
                    end
                    @(posedge clk); #1;
                    k++;
                end while (!ls[2] && k < 100);
                chk("d2_line_period_clks", k, 15);
                chk("d2_hs_high_clks", nhs, 3);
                chk("d2_hs_first_h", hmin, 10);
                chk("d2_hs_last_h", hmax, 12);
                @(negedge clk) rst2 = 1'b0;
                #1;
                chk("d2_async_hcount", hc[2], 14);
                chk("d2_async_vcount", vc[2], 10);
                chk("d2_async_hs", hs[2], 0);
                chk("d2_async_frame_cnt", fc[2], 0);
                chk("d2_async_strobes", {pce[2], ls[2], fs[2]}, 0);
                @(negedge clk) rst2 = 1'b1;
                @(posedge clk); #1;
                chk("d2_restart_hcount", hc[2], 0);
                chk("d2_restart_vcount", vc[2], 0);
                chk("d2_restart_frame_start", fs[2], 1);
                chk("d2_restart_frame_cnt", fc[2], 1);
                repeat (3500) @(negedge clk) begin
                    en2  = ($urandom_range(0, 3) != 0);
                    rst2 = ($urandom_range(0, 299) != 0);
                end
                @(negedge clk) rst2 = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 display timing counter.
- Generates hcount/vcount, the active-video flag vid and the sync pulses hs/vs from a system clock.
- Adds:
  - a pixel-clock prescaler with a pixel clock-enable output,
  - configurable porch/sync widths and sync polarity,
  - line/frame start strobes and a frame counter.
- Sits between the board clock and the pixel/framebuffer logic; every downstream video block qualifies its work with pix_ce and vid.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hs active level (0 = active-low)
- VS_POL, 0, vs active level
- CLK_DIV, 2, system clocks per pixel (>=1)
- CNT_W, 10, width of hcount/vcount (must hold H_TOTAL-1 and V_TOTAL-1)
- FRAME_W, 16, width of frame_cnt

Ports:
- clk  in  1  system clock (50 MHz on board)
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run/freeze control
- hcount  out  CNT_W  current pixel column, 0..H_TOTAL-1
- vcount  out  CNT_W  current line, 0..V_TOTAL-1
- vid  out  1  1 when hcount<H_ACTIVE and vcount<V_ACTIVE
- hs  out  1  horizontal sync, level per HS_POL
- vs  out  1  vertical sync, level per VS_POL
- pix_ce  out  1  one-clk pulse on the first clk of each new pixel
- line_start  out  1  one-clk pulse when hcount becomes 0
- frame_start  out  1  one-clk pulse when (hcount,vcount) becomes (0,0)
- frame_cnt  out  FRAME_W  frames started since reset, wraps

Behaviour:
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- Reset (reset=0, asynchronous):
  - prescaler=0, hcount=H_TOTAL-1, vcount=V_TOTAL-1.
  - vid=0, hs=~HS_POL, vs=~VS_POL.
  - pix_ce=line_start=frame_start=0, frame_cnt=0.
  - The counters park on the last back-porch pixel, so the first tick wraps to (0,0) and raises a clean frame_start.
- Prescaler:
  - Counts 0..CLK_DIV-1 on each clk with enable=1.
  - tick = enable && prescaler==CLK_DIV-1; prescaler returns to 0 on tick.
  - CLK_DIV=1 gives a tick on every enabled clk.
- Counters (update only on tick):
  - hcount increments; at H_TOTAL-1 it wraps to 0 and vcount increments.
  - vcount at V_TOTAL-1 wraps to 0 together with hcount.
- Outputs:
  - All outputs are registered and decoded from the next-state counters, so vid/hs/vs are aligned with hcount/vcount in the same cycle (zero-latency relation).
  - hs = HS_POL when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
  - vs is decoded the same way from vcount using VS_POL.
- Strobes:
  - pix_ce = 1 on the clk following each tick edge, else 0.
  - line_start = pix_ce && hcount==0.
  - frame_start = line_start && vcount==0.
  - frame_cnt increments on the edge that produces frame_start.
- enable=0:
  - Prescaler, counters and frame_cnt hold; vid/hs/vs hold their values.
  - pix_ce, line_start and frame_start are forced to 0.
  - Resuming continues from the held prescaler value, with no phase reset.
- Reset mid-frame:
  - Immediate return to the reset values above.
  - The first tick after release restarts at (0,0) with frame_start=1.
- Parameter checks: elaboration fatal if CLK_DIV<1, any width parameter <1, or 2**CNT_W < max(H_TOTAL,V_TOTAL).

Decomposition:
- Package vga_timing_pkg holds:
  - the standard-mode constant sets (640x480@60 and 800x600@72 porch/sync values),
  - a function computing H_TOTAL/V_TOTAL.
- One natural sub-module, vga_axis_counter, instanced twice (horizontal and vertical). Parameters ACTIVE/FP/SYNC/BP/POL/W; inputs step; outputs count, wrap, in_active, sync.

Test Plan (all defaults unless noted):
- Reset held 5 clks -> hcount=799, vcount=524, vid=0, hs=1, vs=1, frame_cnt=0, all strobes 0.
- Release reset with enable=1 -> on 2nd rising edge hcount=0, vcount=0, vid=1; next cycle pix_ce=line_start=frame_start=1 for exactly 1 clk; frame_cnt=1.
- Run one line -> hs=0 for hcount 656..751 (192 clks); vid=0 from hcount 640; line_start period 1600 clks.
- Run 2 frames -> vs=0 only for vcount 490..491; frame_start period 840000 clks; frame_cnt=2 after second frame start.
- At hcount=100, drop enable for 37 clks -> hcount/vid frozen, no pix_ce; on resume hcount reaches 101 within CLK_DIV clks, no skipped pixel.
- CLK_DIV=1, HS_POL=1, reset asserted at vcount=300 -> hs idles 0 and pulses 1 for 96 clks; after release the first edge gives (0,0) with frame_start=1.
